// File: rtl/message_pkg.sv
// Shared types and default geometry for the on-screen message overlay.
package message_pkg;

    localparam int PIX_W = 11;

    localparam int DEF_TOP_LEFT_X    = 210;
    localparam int DEF_TOP_LEFT_Y    = 190;
    localparam int DEF_OBJECT_WIDTH  = 220;
    localparam int DEF_OBJECT_HEIGHT = 100;
    localparam int DEF_BLINK_FRAMES  = 30;
    localparam int DEF_HOLD_FRAMES   = 120;

    typedef enum logic [1:0] {
        MSG_START   = 2'b00,
        MSG_CLEARED = 2'b01,
        MSG_OVER    = 2'b10,
        MSG_NONE    = 2'b11
    } message_t;

    typedef enum logic [1:0] {
        S_START,
        S_PLAY,
        S_CLEAR,
        S_OVER
    } state_t;

    function automatic message_t state_msg(input state_t s);
        case (s)
            S_START: return MSG_START;
            S_PLAY:  return MSG_NONE;
            S_CLEAR: return MSG_CLEARED;
            default: return MSG_OVER;
        endcase
    endfunction

endpackage

// File: rtl/message_overlay_ctrl_frame_timer.sv
// Frame counter: counts startOfFrame ticks, pulses expire at the limit and wraps to 0.
module frame_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          clear,
    input  logic          tick,
    input  logic [CW-1:0] limit,
    output logic          expire
);

    logic [CW-1:0] count_q, count_d;

    assign expire = tick && (count_q == limit);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick) begin
            count_d = expire ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/message_overlay_ctrl.sv
// Game-phase FSM and message-rectangle pixel decode for the message bitmaps.
// Define MSG_BLINK_EN to blink the START message; otherwise it is shown steadily.
//
// state   | meaning
// S_START | waiting for first key press, START message (optionally blinking)
// S_PLAY  | game running, no message shown
// S_CLEAR | level cleared message held for HOLD_FRAMES frames
// S_OVER  | game over message, key press returns to S_START
module message_overlay_ctrl
    import message_pkg::*;
#(
    parameter int TOP_LEFT_X    = DEF_TOP_LEFT_X,
    parameter int TOP_LEFT_Y    = DEF_TOP_LEFT_Y,
    parameter int OBJECT_WIDTH  = DEF_OBJECT_WIDTH,
    parameter int OBJECT_HEIGHT = DEF_OBJECT_HEIGHT,
    parameter int BLINK_FRAMES  = DEF_BLINK_FRAMES,
    parameter int HOLD_FRAMES   = DEF_HOLD_FRAMES
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [PIX_W-1:0] pixelX,
    input  logic [PIX_W-1:0] pixelY,
    input  logic             startOfFrame,
    input  logic             startKey,
    input  logic             levelCleared,
    input  logic             livesZero,
    output logic [PIX_W-1:0] offsetX,
    output logic [PIX_W-1:0] offsetY,
    output logic             InsideRectangle,
    output logic [1:0]       message,
    output logic             gameRun
);

    localparam int CW = $clog2((BLINK_FRAMES > HOLD_FRAMES) ? BLINK_FRAMES : HOLD_FRAMES) + 1;
    localparam logic [CW-1:0] BLINK_LIM = CW'(BLINK_FRAMES - 1);
    localparam logic [CW-1:0] HOLD_LIM  = CW'(HOLD_FRAMES - 1);

    localparam logic [PIX_W-1:0] X_LO = PIX_W'(TOP_LEFT_X);
    localparam logic [PIX_W-1:0] X_HI = PIX_W'(TOP_LEFT_X + OBJECT_WIDTH);
    localparam logic [PIX_W-1:0] Y_LO = PIX_W'(TOP_LEFT_Y);
    localparam logic [PIX_W-1:0] Y_HI = PIX_W'(TOP_LEFT_Y + OBJECT_HEIGHT);

    state_t           state_q, state_d;
    logic             key_q;
    logic             armed_q, armed_d;
    logic             press;
    logic             timer_clear;
    logic             timer_expire;
    logic [CW-1:0]    timer_limit;
    logic             blink_on;
    logic             hit;
    logic             inside_d;
    logic [PIX_W-1:0] offx_d, offy_d;

    message_t         message_q;
    logic             run_q;
    logic             inside_q;
    logic [PIX_W-1:0] offx_q, offy_q;

    // armed_q blocks a key that was already held when reset released
    assign armed_d = armed_q | ~startKey;
    assign press   = startKey & ~key_q & armed_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_START: if (press) state_d = S_PLAY;
            S_PLAY: begin
                if (livesZero) begin
                    state_d = S_OVER;
                end else if (levelCleared) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: if (timer_expire) state_d = S_PLAY;
            S_OVER:  if (press) state_d = S_START;
            default: state_d = S_START;
        endcase
    end

    assign timer_clear = (state_d != state_q);
    assign timer_limit = (state_q == S_CLEAR) ? HOLD_LIM : BLINK_LIM;

    frame_timer #(
        .CW(CW)
    ) u_frame_timer (
        .clk    (clk),
        .resetN (resetN),
        .clear  (timer_clear),
        .tick   (startOfFrame),
        .limit  (timer_limit),
        .expire (timer_expire)
    );

`ifdef MSG_BLINK_EN
    logic blink_q, blink_d;

    always_comb begin
        blink_d = 1'b1;
        if (state_q == S_START && state_d == S_START) begin
            blink_d = timer_expire ? ~blink_q : blink_q;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            blink_q <= 1'b1;
        end else begin
            blink_q <= blink_d;
        end
    end

    assign blink_on = blink_q;
`else
    assign blink_on = 1'b1;
`endif

    assign hit = (pixelX >= X_LO) && (pixelX < X_HI) &&
                 (pixelY >= Y_LO) && (pixelY < Y_HI);
    assign inside_d = hit & blink_on & (state_q != S_PLAY);
    assign offx_d   = inside_d ? (pixelX - X_LO) : '0;
    assign offy_d   = inside_d ? (pixelY - Y_LO) : '0;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= S_START;
            key_q     <= 1'b0;
            armed_q   <= 1'b0;
            message_q <= MSG_START;
            run_q     <= 1'b0;
            inside_q  <= 1'b0;
            offx_q    <= '0;
            offy_q    <= '0;
        end else begin
            state_q   <= state_d;
            key_q     <= startKey;
            armed_q   <= armed_d;
            message_q <= state_msg(state_d);
            run_q     <= (state_d == S_PLAY);
            inside_q  <= inside_d;
            offx_q    <= offx_d;
            offy_q    <= offy_d;
        end
    end

    assign message         = message_q;
    assign gameRun         = run_q;
    assign InsideRectangle = inside_q;
    assign offsetX         = offx_q;
    assign offsetY         = offy_q;

endmodule

// File: tb/tb_message_overlay_ctrl.sv
// Scoreboard bench for message_overlay_ctrl against a phase/frame-count reference model.
module tb_message_overlay_ctrl;

    localparam int X0 = 210, Y0 = 190, W = 220, H = 100;
    localparam int BLINK = 30, HOLD = 120;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [10:0] pixelX = '0, pixelY = '0;
    logic        startOfFrame = 1'b0, startKey = 1'b0, levelCleared = 1'b0, livesZero = 1'b0;
    logic [10:0] offsetX, offsetY;
    logic        InsideRectangle, gameRun;
    logic [1:0]  message;

    message_overlay_ctrl #(
        .TOP_LEFT_X(X0), .TOP_LEFT_Y(Y0), .OBJECT_WIDTH(W), .OBJECT_HEIGHT(H),
        .BLINK_FRAMES(BLINK), .HOLD_FRAMES(HOLD)
    ) dut (
        .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .startKey(startKey),
        .levelCleared(levelCleared), .livesZero(livesZero),
        .offsetX(offsetX), .offsetY(offsetY), .InsideRectangle(InsideRectangle),
        .message(message), .gameRun(gameRun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ins;
        logic [10:0] ox;
        logic [10:0] oy;
        logic [1:0]  msg;
        logic        run;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // reference model: phase 0=start 1=play 2=clear 3=over, frames = sofs since phase entry
    int m_ph;
    int m_frames;
    bit m_prev_key;
    bit m_seen_low;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit m_blink();
`ifdef MSG_BLINK_EN
        return (m_ph != 0) || (((m_frames / BLINK) % 2) == 0);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [1:0] ph_code(input int ph);
        case (ph)
            0: return 2'b00;
            1: return 2'b11;
            2: return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    task automatic model_reset();
        m_ph = 0;
        m_frames = 0;
        m_prev_key = 1'b0;
        m_seen_low = 1'b0;
    endtask

    task automatic push_expect();
        exp_t e;
        int   x, y, nph;
        bit   press;
        x = int'(pixelX);
        y = int'(pixelY);
        e.ins = (x >= X0) && (x < X0 + W) && (y >= Y0) && (y < Y0 + H) && m_blink() && (m_ph != 1);
        e.ox  = e.ins ? 11'(x - X0) : 11'd0;
        e.oy  = e.ins ? 11'(y - Y0) : 11'd0;
        press = startKey && !m_prev_key && m_seen_low;
        m_prev_key = startKey;
        if (!startKey) m_seen_low = 1'b1;
        nph = m_ph;
        case (m_ph)
            0: if (press) nph = 1;
            1: if (livesZero) nph = 3; else if (levelCleared) nph = 2;
            2: if (startOfFrame && (m_frames + 1 == HOLD)) nph = 1;
            default: if (press) nph = 0;
        endcase
        if (nph != m_ph) m_frames = 0;
        else if (startOfFrame) m_frames++;
        m_ph = nph;
        e.msg = ph_code(m_ph);
        e.run = (m_ph == 1);
        q.push_back(e);
    endtask

    task automatic step(input int x, input int y, input bit sof, input bit key,
                        input bit lc, input bit lz);
        @(negedge clk);
        pixelX = 11'(x);
        pixelY = 11'(y);
        startOfFrame = sof;
        startKey = key;
        levelCleared = lc;
        livesZero = lz;
        push_expect();
    endtask

    task automatic reset_tail(input bit hold_key);
        q.delete();
        model_reset();
        startOfFrame = 1'b0;
        levelCleared = 1'b0;
        livesZero = 1'b0;
        startKey = hold_key;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        push_expect();
    endtask

    task automatic do_reset(input bit hold_key);
        @(negedge clk);
        resetN = 1'b0;
        reset_tail(hold_key);
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #3;
        resetN = 1'b0;
        #1;
        chk("async_rst_inside", int'(InsideRectangle), 0);
        chk("async_rst_offx", int'(offsetX), 0);
        chk("async_rst_offy", int'(offsetY), 0);
        chk("async_rst_msg", int'(message), 0);
        chk("async_rst_run", int'(gameRun), 0);
        reset_tail(1'b0);
    endtask

    task automatic press_key(input int x, input int y);
        step(x, y, 0, 1, 0, 0);
        step(x, y, 0, 0, 0, 0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (resetN && q.size() > 0) begin
            e = q.pop_front();
            chk("inside", int'(InsideRectangle), int'(e.ins));
            chk("offsetX", int'(offsetX), int'(e.ox));
            chk("offsetY", int'(offsetY), int'(e.oy));
            chk("message", int'(message), int'(e.msg));
            chk("gameRun", int'(gameRun), int'(e.run));
        end
    end

    initial begin
        bit key;
        model_reset();
        do_reset(1'b0);

        // rectangle edges in START
        step(210, 190, 0, 0, 0, 0);
        step(430, 190, 0, 0, 0, 0);
        step(209, 190, 0, 0, 0, 0);
        step(429, 289, 0, 0, 0, 0);
        step(210, 290, 0, 0, 0, 0);
        step(300, 189, 0, 0, 0, 0);
        step(300, 220, 0, 0, 0, 0);

        // held key yields a single press
        for (int i = 0; i < 10; i++)
            step($urandom_range(210, 429), $urandom_range(190, 289), 0, 1, 0, 0);
        step(300, 220, 0, 0, 0, 0);
        step(300, 220, 0, 0, 0, 0);

        // livesZero beats levelCleared, then back to START and PLAY
        step(300, 220, 0, 0, 1, 1);
        step(300, 220, 0, 0, 0, 0);
        press_key(300, 220);
        press_key(300, 220);

        // level cleared hold with key presses ignored
        step(300, 220, 0, 0, 1, 0);
        for (int f = 0; f < 125; f++) begin
            step(300, 220, 1, (f % 7) == 3, 0, 0);
            step(300, 220, 0, 0, 0, 0);
            step(300, 220, 0, 0, 0, 0);
        end

        // game over, back to START, blink window
        step(300, 220, 0, 0, 0, 1);
        step(300, 220, 0, 0, 0, 0);
        press_key(300, 220);
        for (int f = 0; f < 100; f++) begin
            step(300, 220, 1, 0, 0, 0);
            step(300, 220, 0, 0, 0, 0);
            step(300, 220, 0, 0, 0, 0);
        end

        // randomized traffic
        key = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            int x, y;
            if ($urandom_range(0, 5) == 0) key = ~key;
            x = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2047) : $urandom_range(190, 450);
            y = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2047) : $urandom_range(170, 310);
            step(x, y, $urandom_range(0, 3) == 0, key,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0);
        end

        // asynchronous reset in the middle of a CLEAR hold
        do_reset(1'b0);
        press_key(300, 220);
        step(300, 220, 0, 0, 1, 0);
        for (int f = 0; f < 50; f++) begin
            step(300, 220, 1, 0, 0, 0);
            step(300, 220, 0, 0, 0, 0);
        end
        mid_reset();
        step(210, 190, 0, 0, 0, 0);
        for (int f = 0; f < 40; f++) begin
            step(250, 250, 1, 0, 0, 0);
            step(250, 250, 0, 0, 0, 0);
        end

        // key held through reset release gives no press
        do_reset(1'b1);
        for (int i = 0; i < 10; i++) step(300, 220, 0, 1, 0, 0);
        step(300, 220, 0, 0, 0, 0);
        press_key(300, 220);
        step(300, 220, 0, 0, 1, 0);
        for (int f = 0; f < 122; f++) begin
            step(300, 220, 1, 0, 0, 0);
            step(300, 220, 0, 0, 0, 0);
        end

        step(300, 220, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
